// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizes Rx_i, oversamples 8x on AcqSig_i, majority-votes
// each bit and reports data/parity/frame/overrun status to the host.
// Ports: clk, rst (sync, active-high), AcqSig_i tick, RxEn_i, Rx_i line,
//   ParityEn_i/ParityOdd_i config, RxRead_i host ack; RxData_o word,
//   RxReady_o, RxValid_o, ParityErr_o, FrameErr_o, Overrun_o, Busy_o status.
module uart_rx_engine #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic       RxEn_i,
  input  logic       Rx_i,
  input  logic       ParityEn_i,
  input  logic       ParityOdd_i,
  input  logic       RxRead_i,
  output logic [7:0] RxData_o,
  output logic       RxReady_o,
  output logic       RxValid_o,
  output logic       ParityErr_o,
  output logic       FrameErr_o,
  output logic       Overrun_o,
  output logic       Busy_o
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line;
  logic [2:0]             tick;
  logic [2:0]             bit_cnt;
  logic                   s3, s4;
  logic                   maj;
  logic [DATA_BITS-1:0]   shreg;
  logic [7:0]             word;
  logic                   par_en, par_odd;
  logic                   perr_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], Rx_i};
  end

  assign line = sync_q[SYNC_STAGES-1];

  // Majority of samples at ticks 3, 4 and the current tick 5.
  assign maj = (s3 & s4) | (s3 & line) | (s4 & line);

  always_comb begin
    word = '0;
    word[DATA_BITS-1:0] = shreg;
  end

  assign Busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tick        <= '0;
      bit_cnt     <= '0;
      s3          <= 1'b1;
      s4          <= 1'b1;
      shreg       <= '0;
      par_en      <= 1'b0;
      par_odd     <= 1'b0;
      perr_q      <= 1'b0;
      RxData_o    <= '0;
      RxReady_o   <= 1'b0;
      RxValid_o   <= 1'b0;
      ParityErr_o <= 1'b0;
      FrameErr_o  <= 1'b0;
      Overrun_o   <= 1'b0;
    end else begin
      RxValid_o <= 1'b0;
      if (RxRead_i) begin
        RxReady_o <= 1'b0;
        Overrun_o <= 1'b0;
      end
      if (!RxEn_i) begin
        state   <= IDLE;
        tick    <= '0;
        bit_cnt <= '0;
      end else if (AcqSig_i) begin
        if (state != IDLE && state != BREAK)
          tick <= tick + 3'd1;
        if (tick == 3'd3) s3 <= line;
        if (tick == 3'd4) s4 <= line;
        unique case (state)
          IDLE: begin
            tick <= '0;
            if (!line) state <= START;
          end
          START: begin
            if (tick == 3'd5 && maj) begin
              state <= IDLE;
              tick  <= '0;
            end else if (tick == 3'd7) begin
              state   <= DATA;
              bit_cnt <= '0;
              par_en  <= ParityEn_i;
              par_odd <= ParityOdd_i;
              perr_q  <= 1'b0;
            end
          end
          DATA: begin
            if (tick == 3'd5)
              shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (tick == 3'd7) begin
              if (bit_cnt == 3'(DATA_BITS - 1))
                state <= par_en ? PARITY : STOP;
              else
                bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PARITY: begin
            if (tick == 3'd5)
              perr_q <= maj ^ (^shreg) ^ par_odd;
            if (tick == 3'd7)
              state <= STOP;
          end
          STOP: begin
            if (tick == 3'd5) begin
              RxData_o    <= word;
              RxValid_o   <= 1'b1;
              RxReady_o   <= 1'b1;
              ParityErr_o <= par_en & perr_q;
              FrameErr_o  <= ~maj;
              if (RxReady_o && !RxRead_i)
                Overrun_o <= 1'b1;
              tick  <= '0;
              state <= (!maj && shreg == '0) ? BREAK : IDLE;
            end
          end
          BREAK: begin
            tick <= '0;
            if (line) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 Parameter: DATA_BITS, 8, number of data bits per frame; legal range 5..8.
REQ-002 Parameter: SYNC_STAGES, 2, number of synchronizer flops on the line input; minimum 2.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 AcqSig_i  input  1  one-clk oversample tick from the baudrate generator; 8 ticks per bit.
REQ-006 RxEn_i  input  1  receiver enable; low aborts any frame in progress.
REQ-007 Rx_i  input  1  asynchronous serial line; idle high.
REQ-008 ParityEn_i  input  1  parity bit present after the data bits when high.
REQ-009 ParityOdd_i  input  1  odd parity when high, even parity when low.
REQ-010 RxRead_i  input  1  one-clk pulse; host has consumed RxData_o.
REQ-011 RxData_o  output  8  received word, LSB-aligned; bits above DATA_BITS are 0.
REQ-012 RxReady_o  output  1  level; unread word held in RxData_o.
REQ-013 RxValid_o  output  1  one-clk pulse per completed frame.
REQ-014 ParityErr_o  output  1  parity result of the last completed frame.
REQ-015 FrameErr_o  output  1  stop-bit result of the last completed frame.
REQ-016 Overrun_o  output  1  sticky; a frame completed while RxReady_o was already high.
REQ-017 Busy_o  output  1  high in every state except IDLE.

Function
REQ-018 Rx_i shall pass through SYNC_STAGES flops (reset value 1) before any use.
REQ-019 The synchronized line shall be examined only in clk cycles where AcqSig_i=1.
REQ-020 States: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-021 A tick counter of 3 bits shall count ticks 0..7 within each bit and wrap 7->0 at each bit boundary.
REQ-022 IDLE->START on a tick with line=0; tick counter set to 0 on that tick.
REQ-023 Bit value = majority of the line samples at ticks 3, 4 and 5 of the bit.
REQ-024 START: majority=1 at tick 5 -> false start, return to IDLE; majority=0 -> DATA at tick 7.
REQ-025 DATA: bits shift in LSB first; after DATA_BITS bits -> PARITY if ParityEn_i=1, else STOP, at tick 7.
REQ-026 PARITY: ParityErr = received bit differs from the computed bit (XOR of data bits, inverted if ParityOdd_i=1).
REQ-027 STOP: at tick 5 the frame completes; FrameErr = (stop majority = 0).
REQ-028 Frame completion, registered on the next clk: RxData_o loaded; RxValid_o=1 for one clk; RxReady_o=1; ParityErr_o and FrameErr_o updated (ParityErr_o=0 when parity is disabled).
REQ-029 Completion with FrameErr=1 and all data bits 0 -> BREAK; otherwise -> IDLE.
REQ-030 BREAK -> IDLE on the first tick with line=1; no start is detected while in BREAK.
REQ-031 RxReady_o shall clear on RxRead_i; Overrun_o shall clear on RxRead_i.
REQ-032 Completion while RxReady_o=1 and RxRead_i=0: set Overrun_o and overwrite RxData_o with the new word.
REQ-033 Completion coincident with RxRead_i=1: RxReady_o stays 1; Overrun_o is not set.
REQ-034 RxEn_i=0: state -> IDLE next clk and the partial frame is discarded; RxData_o, RxReady_o and the error flags hold.
REQ-035 ParityEn_i and ParityOdd_i shall be sampled at the START->DATA transition and held for the rest of the frame.
REQ-036 AcqSig_i=0 cycles shall change no state other than the synchronizer and the RxRead_i clears.

Reset
REQ-037 On rst=1: state IDLE; counters 0; synchronizer all 1; RxData_o=0; RxReady_o, RxValid_o, ParityErr_o, FrameErr_o, Overrun_o and Busy_o all 0.
REQ-038 rst mid-frame shall abort the frame within one clk, with no RxValid_o pulse.

Verification
REQ-039 8N1, byte 0xA5, clean line -> RxData_o=0xA5, one RxValid_o pulse, RxReady_o=1, ParityErr_o=0, FrameErr_o=0.
REQ-040 8E1, byte 0x07 sent with parity 0 (wrong) -> RxData_o=0x07, ParityErr_o=1; repeat with parity 1 -> ParityErr_o=0.
REQ-041 Low glitch on Rx_i lasting 2 ticks -> START then IDLE, no RxValid_o, Busy_o back to 0.
REQ-042 Two frames 0x11 then 0x22 with no RxRead_i -> RxData_o=0x22, Overrun_o=1; one RxRead_i -> RxReady_o=0, Overrun_o=0.
REQ-043 Line held low for 20 bit times -> FrameErr_o=1, RxData_o=0x00, state BREAK; line high then frame 0x3C -> RxData_o=0x3C received normally.
REQ-044 rst or RxEn_i=0 asserted at data bit 4 of a frame -> IDLE next clk, no RxValid_o; a following 0x5A frame is received correctly.
